shift_seq: RTL

Parametrised successor to the sqrt ASM datapath shift register. It is a WIDTH-bit register with parallel load and single-step shifting. It also has a built-in sequencer that performs an N-position shift on one `start` command, then pulses `done`. Shifts are bidirectional and support logical, arithmetic, rotate and serial-in fill modes. It serves the iterative arithmetic cores (sqrt, mult, div) that currently hand-count shift cycles in their own control FSMs.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_step.sv | 40 ++++
 rtl/shift_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the shift_seq register and its step logic.
// Holds mode/direction constants and the sequencer state type.
package shift_pkg;

    localparam logic [1:0] SH_LOGIC  = 2'b00;
    localparam logic [1:0] SH_ARITH  = 2'b01;
    localparam logic [1:0] SH_ROT    = 2'b10;
    localparam logic [1:0] SH_SERIAL = 2'b11;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// One-position combinational shifter shared by single-step and sequenced paths.
// Ports: value_i, dir_i, mode_i, in_bit_i -> value_o (shifted), out_bit_o (bit that left).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             in_bit_i,
    output logic [WIDTH-1:0] value_o,
    output logic             out_bit_o
);

    logic fill;

    // Bit entering the vacated end.
    always_comb begin
        fill = 1'b0;
        case (mode_i)
            SH_LOGIC:  fill = 1'b0;
            SH_ARITH:  fill = (dir_i == SH_RIGHT) ? value_i[WIDTH-1] : 1'b0;
            SH_ROT:    fill = (dir_i == SH_RIGHT) ? value_i[0] : value_i[WIDTH-1];
            SH_SERIAL: fill = in_bit_i;
            default:   fill = 1'b0;
        endcase
    end

    always_comb begin
        if (dir_i == SH_RIGHT) begin
            value_o   = {fill, value_i[WIDTH-1:1]};
            out_bit_o = value_i[0];
        end else begin
            value_o   = {value_i[WIDTH-2:0], fill};
            out_bit_o = value_i[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Shift register with parallel load, single-step shift and an N-step sequencer.
// Ports: clk, reset, load, in_A, shift, start, count, dir, mode, in_bit -> out_r, out_bit, busy, done.
module shift_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in_A,
    input  logic             shift,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_r,
    output logic             out_bit,
    output logic             busy,
    output logic             done
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ob_q, ob_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] n_sat;
    logic             step_dir;
    logic [1:0]       step_mode;
    logic [WIDTH-1:0] step_val;
    logic             step_ob;

    assign n_sat = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

    // RUN uses the command's latched controls; IDLE uses live inputs.
    assign step_dir  = (state_q == S_RUN) ? dir_q  : dir;
    assign step_mode = (state_q == S_RUN) ? mode_q : mode;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value_i  (r_q),
        .dir_i    (step_dir),
        .mode_i   (step_mode),
        .in_bit_i (in_bit),
        .value_o  (step_val),
        .out_bit_o(step_ob)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        r_d     = r_q;
        ob_d    = ob_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    r_d  = in_A;
                    ob_d = 1'b0;
                end else if (start) begin
                    dir_d  = dir;
                    mode_d = mode;
                    if (n_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = n_sat;
                    end
                end else if (shift) begin
                    r_d  = step_val;
                    ob_d = step_ob;
                end
            end
            S_RUN: begin
                r_d   = step_val;
                ob_d  = step_ob;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Falling-edge clocking matches the other sqrt ASM cores.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dir_q   <= SH_LEFT;
            mode_q  <= SH_LOGIC;
            r_q     <= '0;
            ob_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            r_q     <= r_d;
            ob_q    <= ob_d;
            done_q  <= done_d;
        end
    end

    assign out_r   = r_q;
    assign out_bit = ob_q;
    assign busy    = (state_q == S_RUN);
    assign done    = done_q;

endmodule
